// File: rtl/axi_ram_fill_sequencer_pkg.sv
// axi_fill_pkg: AXI encodings, FSM states and constants shared by the fill/verify sequencers
package axi_fill_pkg;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [12:0] BOUNDARY_4K = 13'h1000;
    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;
endpackage

// File: rtl/axi_ram_fill_sequencer_burst_len_calc.sv
// axi_burst_len_calc: beats in next burst = min(max_len+1, remaining, beats left before the 4 KB boundary)
// Ports: i_addr_lo = low 12 bits of the aligned burst address, i_remaining = beats still to issue,
//        i_max_len = AXI-encoded length cap, o_len = beat count (not AXI-encoded)
module axi_burst_len_calc #(
    parameter int CNT_WIDTH = 15,
    parameter int SIZE_LOG2 = 2
) (
    input  logic [11:0]          i_addr_lo,
    input  logic [CNT_WIDTH-1:0] i_remaining,
    input  logic [7:0]           i_max_len,
    output logic [CNT_WIDTH-1:0] o_len
);
    import axi_fill_pkg::*;
    logic [12:0]          w_room_bytes;
    logic [CNT_WIDTH-1:0] w_room;
    logic [CNT_WIDTH-1:0] w_max;
    logic [CNT_WIDTH-1:0] w_min_a;
    always_comb begin
        w_room_bytes = BOUNDARY_4K - {1'b0, i_addr_lo};
        w_room = CNT_WIDTH'(w_room_bytes >> SIZE_LOG2);
        w_max = CNT_WIDTH'({1'b0, i_max_len} + 9'd1);
        w_min_a = (w_max < i_remaining) ? w_max : i_remaining;
        o_len = (w_room < w_min_a) ? w_room : w_min_a;
    end
endmodule

// File: rtl/axi_ram_fill_sequencer.sv
// axi_ram_fill_sequencer: AXI4 write master filling a region with INCR bursts, one burst outstanding
// Ports: start/base_addr/beat_count/max_len/pattern_sel/fill_value = command in;
//        busy/done/err = status out; m_axi_aw*/w*/b* = AXI4 write channels to the RAM
module axi_ram_fill_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int AXI_ID     = 0,
    parameter int CNT_WIDTH  = ADDR_WIDTH - $clog2(STRB_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  beat_count,
    input  logic [7:0]            max_len,
    input  logic                  pattern_sel,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);
    import axi_fill_pkg::*;
    localparam int SIZE_LOG2 = $clog2(STRB_WIDTH);
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic [7:0]            r_max_len;
    logic [7:0]            r_beat;
    logic                  r_pattern_sel;
    logic [DATA_WIDTH-1:0] r_fill;
    logic [7:0]            r_awlen;
    logic                  r_awvalid;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_wvalid;
    logic                  r_wlast;
    logic                  r_bready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  w_idle;
    logic [ADDR_WIDTH-1:0] w_base_aligned;
    logic [ADDR_WIDTH-1:0] w_calc_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [ADDR_WIDTH-1:0] w_data_addr;
    logic [CNT_WIDTH-1:0]  w_calc_rem;
    logic [CNT_WIDTH-1:0]  w_len;
    logic [7:0]            w_calc_max;
    logic [DATA_WIDTH-1:0] w_wdata_next;
    logic                  w_unused;
    // In IDLE the length is taken straight from the command so awvalid can rise the cycle after start.
    always_comb begin
        w_idle = r_state == ST_IDLE;
        w_base_aligned = base_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
        w_calc_addr = w_idle ? w_base_aligned : r_addr;
        w_calc_rem = w_idle ? beat_count : r_remaining;
        w_calc_max = w_idle ? max_len : r_max_len;
        w_addr_next = r_addr + ADDR_WIDTH'(STRB_WIDTH);
        w_data_addr = (r_state == ST_W) ? w_addr_next : r_addr;
        w_wdata_next = r_pattern_sel ? DATA_WIDTH'(w_data_addr) : r_fill;
        w_unused = &{1'b0, m_axi_bid, w_calc_addr[ADDR_WIDTH-1:12]};
    end
    axi_burst_len_calc #(.CNT_WIDTH(CNT_WIDTH), .SIZE_LOG2(SIZE_LOG2)) u_len (
        .i_addr_lo  (w_calc_addr[11:0]),
        .i_remaining(w_calc_rem),
        .i_max_len  (w_calc_max),
        .o_len      (w_len)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr <= '0;
            r_remaining <= '0;
            r_max_len <= '0;
            r_beat <= '0;
            r_pattern_sel <= 1'b0;
            r_fill <= '0;
            r_awlen <= '0;
            r_awvalid <= 1'b0;
            r_wdata <= '0;
            r_wvalid <= 1'b0;
            r_wlast <= 1'b0;
            r_bready <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_err <= 1'b0;
                    if (beat_count == '0) begin
                        r_done <= 1'b1;
                    end else begin
                        r_addr <= w_base_aligned;
                        r_remaining <= beat_count;
                        r_max_len <= max_len;
                        r_pattern_sel <= pattern_sel;
                        r_fill <= fill_value;
                        r_awlen <= 8'(w_len - 1'b1);
                        r_awvalid <= 1'b1;
                        r_busy <= 1'b1;
                        r_state <= ST_AW;
                    end
                end
                ST_AW: if (m_axi_awready) begin
                    r_awvalid <= 1'b0;
                    r_wvalid <= 1'b1;
                    r_wdata <= w_wdata_next;
                    r_wlast <= r_awlen == 8'd0;
                    r_beat <= '0;
                    r_state <= ST_W;
                end
                ST_W: if (m_axi_wready) begin
                    r_addr <= w_addr_next;
                    r_remaining <= r_remaining - 1'b1;
                    if (r_wlast) begin
                        r_wvalid <= 1'b0;
                        r_wlast <= 1'b0;
                        r_bready <= 1'b1;
                        r_state <= ST_B;
                    end else begin
                        r_beat <= r_beat + 8'd1;
                        r_wdata <= w_wdata_next;
                        r_wlast <= (r_beat + 8'd1) == r_awlen;
                    end
                end
                ST_B: if (m_axi_bvalid) begin
                    r_bready <= 1'b0;
                    if (m_axi_bresp != RESP_OKAY) r_err <= 1'b1;
                    if (r_remaining == '0) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_awlen <= 8'(w_len - 1'b1);
                        r_awvalid <= 1'b1;
                        r_state <= ST_AW;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign busy = r_busy;
    assign done = r_done;
    assign err = r_err;
    assign m_axi_awid = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr = r_addr;
    assign m_axi_awlen = r_awlen;
    assign m_axi_awsize = 3'(SIZE_LOG2);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata = r_wdata;
    assign m_axi_wstrb = '1;
    assign m_axi_wlast = r_wlast;
    assign m_axi_wvalid = r_wvalid;
    assign m_axi_bready = r_bready;
endmodule

// File: tb/tb_axi_ram_fill_sequencer.sv
// tb_axi_ram_fill_sequencer: directed fill commands against a scoreboarded AXI write slave model
module tb_axi_ram_fill_sequencer;
    typedef struct packed {logic [15:0] addr; logic [7:0] len;} aw_t;
    typedef struct packed {logic l; logic [31:0] d;} w_t;
    typedef struct packed {logic e; logic hb;} d_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [14:0] beat_count = '0;
    logic [7:0] max_len = '0;
    logic pattern_sel = 1'b0;
    logic [31:0] fill_value = '0;
    logic busy, done, err;
    logic [7:0] awid;
    logic [15:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic awvalid, wvalid, wlast, bready;
    logic awready = 1'b0;
    logic wready = 1'b0;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic [7:0] bid = '0;
    logic [1:0] bresp = '0;
    logic bvalid = 1'b0;
    aw_t exp_aw[$];
    w_t exp_w[$];
    d_t exp_d[$];
    logic [31:0] mem [int];
    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, w_cnt = 0, burst_idx = 0;
    int aw_delay = 0, b_delay = 0, err_burst = -1;
    logic w_rand = 1'b0;
    always #5 clk = ~clk;
    axi_ram_fill_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .beat_count(beat_count),
        .max_len(max_len), .pattern_sel(pattern_sel), .fill_value(fill_value),
        .busy(busy), .done(done), .err(err),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready)
    );
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask
    task automatic bad(input string n);
        checks++;
        errors++;
        $display("FAIL %s", n);
    endtask
    task automatic push_burst(input logic [15:0] a, input logic [7:0] len, input logic ps, input logic [31:0] fv);
        exp_aw.push_back('{a, len});
        for (int i = 0; i <= int'(len); i++)
            exp_w.push_back('{i == int'(len), ps ? 32'(16'(a + 16'(4 * i))) : fv});
    endtask
    task automatic cmd(input logic [15:0] b, input logic [14:0] n, input logic [7:0] ml, input logic ps, input logic [31:0] fv);
        @(negedge clk);
        base_addr = b;
        beat_count = n;
        max_len = ml;
        pattern_sel = ps;
        fill_value = fv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (done_cnt < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt < target) bad("done_timeout");
    endtask
    initial begin : monitor
        int aw_cnt, b_cnt, waddr, last_b;
        logic b_pend, aw_done, pw_stall, pa_stall, pw_last;
        logic [31:0] pw_data;
        logic [15:0] pa_addr;
        logic [7:0] pa_len;
        aw_t ea;
        w_t ew;
        d_t ed;
        aw_cnt = 0; b_cnt = 0; waddr = 0; last_b = -100;
        b_pend = 0; aw_done = 0; pw_stall = 0; pa_stall = 0; pw_last = 0;
        pw_data = '0; pa_addr = '0; pa_len = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                aw_cnt = 0; b_cnt = 0; b_pend = 0; aw_done = 0; pw_stall = 0; pa_stall = 0;
            end else begin
                awready = awvalid && aw_cnt >= aw_delay;
                wready = w_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                bvalid = b_pend && b_cnt >= b_delay;
                bresp = (bvalid && burst_idx == err_burst) ? 2'b10 : 2'b00;
                if (pa_stall) chk("aw_stable", {awvalid, awaddr, awlen}, {1'b1, pa_addr, pa_len});
                if (pw_stall) chk("w_stable", {wvalid, wlast, wdata}, {1'b1, pw_last, pw_data});
                if (wvalid) chk("w_after_aw", aw_done, 1'b1);
                pa_stall = awvalid && !awready;
                pa_addr = awaddr;
                pa_len = awlen;
                pw_stall = wvalid && !wready;
                pw_data = wdata;
                pw_last = wlast;
                if (awvalid && awready) begin
                    if (exp_aw.size() == 0) bad("aw_unexpected");
                    else begin
                        ea = exp_aw.pop_front();
                        chk("aw", {awaddr, awlen}, {ea.addr, ea.len});
                    end
                    chk("aw_fixed", {awid, awsize, awburst, wstrb}, {8'h00, 3'd2, 2'b01, 4'hF});
                    aw_cnt = 0;
                    aw_done = 1;
                    waddr = int'(awaddr);
                end else if (awvalid) aw_cnt++;
                if (wvalid && wready) begin
                    if (exp_w.size() == 0) bad("w_unexpected");
                    else begin
                        ew = exp_w.pop_front();
                        chk("w", {wlast, wdata}, {ew.l, ew.d});
                    end
                    mem[waddr] = wdata;
                    waddr = (waddr + 4) & 'hFFFF;
                    w_cnt++;
                    if (wlast) begin
                        b_pend = 1;
                        b_cnt = 0;
                    end
                end
                if (bvalid && bready) begin
                    b_pend = 0;
                    aw_done = 0;
                    burst_idx++;
                    last_b = cyc;
                end else if (b_pend) b_cnt++;
                if (done) begin
                    if (exp_d.size() == 0) bad("done_unexpected");
                    else begin
                        ed = exp_d.pop_front();
                        chk("done_err", err, ed.e);
                        if (ed.hb) chk("done_timing", 64'(cyc), 64'(last_b + 1));
                    end
                    done_cnt++;
                end
            end
        end
    end
    initial begin : stim
        int nd, tgt, k;
        nd = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", {busy, done, err, awvalid, wvalid, wlast, bready, awaddr, awlen, wdata}, '0);
        rst = 1'b0;
        push_burst(16'h0000, 8'd3, 1'b0, 32'hA5A5A5A5);
        exp_d.push_back('{1'b0, 1'b1});
        cmd(16'h0000, 15'd4, 8'd3, 1'b0, 32'hA5A5A5A5);
        wait_done(++nd);
        for (int i = 0; i < 4; i++) chk("ram_const", mem[4 * i], 32'hA5A5A5A5);
        push_burst(16'h0FF8, 8'd1, 1'b1, '0);
        push_burst(16'h1000, 8'd3, 1'b1, '0);
        exp_d.push_back('{1'b0, 1'b1});
        cmd(16'h0FF8, 15'd6, 8'd15, 1'b1, '0);
        wait_done(++nd);
        err_burst = burst_idx + 1;
        push_burst(16'h0100, 8'd3, 1'b0, 32'h12345678);
        push_burst(16'h0110, 8'd3, 1'b0, 32'h12345678);
        push_burst(16'h0120, 8'd1, 1'b0, 32'h12345678);
        exp_d.push_back('{1'b1, 1'b1});
        cmd(16'h0100, 15'd10, 8'd3, 1'b0, 32'h12345678);
        wait_done(++nd);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1'b1);
        err_burst = -1;
        aw_delay = 5;
        b_delay = 2;
        w_rand = 1'b1;
        push_burst(16'h0200, 8'd6, 1'b1, '0);
        exp_d.push_back('{1'b0, 1'b1});
        cmd(16'h0201, 15'd7, 8'd7, 1'b1, '0);
        chk("err_cleared", {err, busy}, 2'b01);
        wait_done(++nd);
        for (int i = 0; i < 7; i++) chk("ram_addr", mem['h200 + 4 * i], 32'('h200 + 4 * i));
        aw_delay = 0;
        b_delay = 0;
        w_rand = 1'b0;
        push_burst(16'h0300, 8'd7, 1'b0, 32'hDEADBEEF);
        tgt = w_cnt + 3;
        cmd(16'h0300, 15'd8, 8'd7, 1'b0, 32'hDEADBEEF);
        k = 0;
        while (w_cnt < tgt && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (w_cnt < tgt) bad("w_timeout");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", {wvalid, awvalid, busy, err, bready}, '0);
        rst = 1'b0;
        exp_aw.delete();
        exp_w.delete();
        exp_d.push_back('{1'b0, 1'b0});
        cmd(16'h0500, 15'd0, 8'd3, 1'b0, '0);
        chk("zero_done", {done, awvalid, busy}, 3'b100);
        wait_done(++nd);
        for (int i = 0; i < 3; i++) push_burst(16'(16'h0400 + 4 * i), 8'd0, 1'b0, 32'h0F0F0F0F);
        exp_d.push_back('{1'b0, 1'b1});
        cmd(16'h0400, 15'd3, 8'd0, 1'b0, 32'h0F0F0F0F);
        wait_done(++nd);
        push_burst(16'hFFF8, 8'd1, 1'b1, '0);
        push_burst(16'h0000, 8'd1, 1'b1, '0);
        exp_d.push_back('{1'b0, 1'b1});
        cmd(16'hFFF8, 15'd4, 8'd3, 1'b1, '0);
        wait_done(++nd);
        repeat (5) @(negedge clk);
        chk("queues_empty", 64'(exp_aw.size() + exp_w.size() + exp_d.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
